// File: rtl/odmb_vme_pkg.sv
// Shared types and defaults for schedulers that front the ODMB VME command decoder.
package odmb_vme_pkg;

  localparam logic [31:0] IDLE_CMD_DEFAULT = 32'h00F8_0000;
  localparam int unsigned RD_BIT_DEFAULT   = 25;
  localparam int unsigned RSP_ID_W         = 3;
  localparam int unsigned VME_W            = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic [VME_W-1:0]    data;
    logic                rd;
    logic                timeout;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first valid index at or after ptr, modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!any_c && valid[cand]) begin
        any_c         = 1'b1;
        grant_c[cand] = 1'b1;
        idx_c         = cand;
      end
    end
  end

endmodule

// File: rtl/vme_cmd_arbiter.sv
// Round-robin scheduler sharing the single ODMB VME command path between requesters;
// one command outstanding, read-back or timeout returned to the granted requester.
module vme_cmd_arbiter
  import odmb_vme_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned TIMEOUT  = 1023,
  parameter logic [31:0] IDLE_CMD = IDLE_CMD_DEFAULT,
  parameter int unsigned RD_BIT   = RD_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_cmd,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 vme_cmd_rd,
  input  logic                 vme_dat_wr,
  input  logic [31:0]          vme_dat_reg_out,
  output logic                 start,
  output logic [31:0]          vme_cmd_reg,
  output logic [31:0]          vme_dat_reg_in,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_rd,
  output logic                 rsp_timeout
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [31:0] cmd_arr [NREQ];
  logic [31:0] dat_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign cmd_arr[g] = req_cmd[32*g +: 32];
    assign dat_arr[g] = req_data[32*g +: 32];
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            go_q, go_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     cmd_lat_q, cmd_lat_d;
  logic [31:0]     dat_lat_q, dat_lat_d;
  logic [2:0]      id_lat_q, id_lat_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            start_q, start_d;
  logic [31:0]     cmd_out_q, cmd_out_d;
  logic [31:0]     dat_out_q, dat_out_d;
  logic            rsp_valid_q, rsp_valid_d;
  rsp_t            rsp_q, rsp_d;

  logic [NREQ-1:0] grant_c;
  logic [IW-1:0]   idx_c;
  logic            any_c;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .valid   (req_valid),
    .ptr     (ptr_q),
    .grant_c (grant_c),
    .idx_c   (idx_c),
    .any_c   (any_c)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    go_d        = go_q;
    cnt_d       = cnt_q;
    cmd_lat_d   = cmd_lat_q;
    dat_lat_d   = dat_lat_q;
    id_lat_d    = id_lat_q;
    req_ready_d = '0;
    start_d     = 1'b0;
    cmd_out_d   = IDLE_CMD;
    dat_out_d   = '0;
    rsp_valid_d = 1'b0;
    rsp_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (any_c) begin
          req_ready_d = grant_c;
          cmd_lat_d   = cmd_arr[idx_c];
          dat_lat_d   = dat_arr[idx_c];
          id_lat_d    = 3'(idx_c);
          ptr_d       = (idx_c == IW'(NREQ - 1)) ? '0 : IW'(idx_c + IW'(1));
          go_d        = 1'b0;
          state_d     = S_ISSUE;
        end
      end

      // vme_cmd_rd is sampled once, then the command is driven on the following cycle
      S_ISSUE: begin
        if (go_q) begin
          start_d   = 1'b1;
          cmd_out_d = cmd_lat_q;
          dat_out_d = dat_lat_q;
          cnt_d     = '0;
          go_d      = 1'b0;
          state_d   = S_WAIT;
        end else if (vme_cmd_rd) begin
          go_d = 1'b1;
        end
      end

      // counting starts after the start cycle; a strobe beats a coincident timeout
      S_WAIT: begin
        if (!start_q && cnt_q != CW'(TIMEOUT)) begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
        if (vme_dat_wr) begin
          rsp_valid_d = 1'b1;
          rsp_d.id    = id_lat_q;
          rsp_d.rd    = cmd_lat_q[RD_BIT];
          rsp_d.data  = cmd_lat_q[RD_BIT] ? vme_dat_reg_out : 32'h0;
          state_d     = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rsp_valid_d   = 1'b1;
          rsp_d.id      = id_lat_q;
          rsp_d.rd      = cmd_lat_q[RD_BIT];
          rsp_d.timeout = 1'b1;
          state_d       = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      go_q        <= 1'b0;
      cnt_q       <= '0;
      cmd_lat_q   <= '0;
      dat_lat_q   <= '0;
      id_lat_q    <= '0;
      req_ready_q <= '0;
      start_q     <= 1'b0;
      cmd_out_q   <= IDLE_CMD;
      dat_out_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      go_q        <= go_d;
      cnt_q       <= cnt_d;
      cmd_lat_q   <= cmd_lat_d;
      dat_lat_q   <= dat_lat_d;
      id_lat_q    <= id_lat_d;
      req_ready_q <= req_ready_d;
      start_q     <= start_d;
      cmd_out_q   <= cmd_out_d;
      dat_out_q   <= dat_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign start          = start_q;
  assign vme_cmd_reg    = cmd_out_q;
  assign vme_dat_reg_in = dat_out_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_q.id;
  assign rsp_data       = rsp_q.data;
  assign rsp_rd         = rsp_q.rd;
  assign rsp_timeout    = rsp_q.timeout;

endmodule

// File: tb/tb_vme_cmd_arbiter.sv
// Directed bench for vme_cmd_arbiter (NREQ=2, TIMEOUT=16) with hand-computed cycle timing.
module tb_vme_cmd_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_cmd;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        vme_cmd_rd;
  logic        vme_dat_wr;
  logic [31:0] vme_dat_reg_out;
  logic        start;
  logic [31:0] vme_cmd_reg;
  logic [31:0] vme_dat_reg_in;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_rd;
  logic        rsp_timeout;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  vme_cmd_arbiter #(
    .NREQ     (2),
    .TIMEOUT  (16),
    .IDLE_CMD (32'h00F8_0000),
    .RD_BIT   (25)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_cmd         (req_cmd),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .vme_cmd_rd      (vme_cmd_rd),
    .vme_dat_wr      (vme_dat_wr),
    .vme_dat_reg_out (vme_dat_reg_out),
    .start           (start),
    .vme_cmd_reg     (vme_cmd_reg),
    .vme_dat_reg_in  (vme_dat_reg_in),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_data        (rsp_data),
    .rsp_rd          (rsp_rd),
    .rsp_timeout     (rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int early;
    int stall_bad;
    logic [1:0] exp_ready;
    rst = 1'b1; req_valid = '0; req_cmd = '0; req_data = '0;
    vme_cmd_rd = 1'b0; vme_dat_wr = 1'b0; vme_dat_reg_out = '0;
    step(); step();

    chk("rst_start",   32'(start), 32'h0);
    chk("rst_cmd",     vme_cmd_reg, 32'h00F8_0000);
    chk("rst_dat",     vme_dat_reg_in, 32'h0);
    chk("rst_ready",   32'(req_ready), 32'h0);
    chk("rst_rspv",    32'(rsp_valid), 32'h0);
    chk("rst_rspid",   32'(rsp_id), 32'h0);
    chk("rst_rspdata", rsp_data, 32'h0);
    chk("rst_rsprd",   32'(rsp_rd), 32'h0);
    chk("rst_rspto",   32'(rsp_timeout), 32'h0);
    rst = 1'b0;

    // single write from requester 0, decoder already ready
    vme_cmd_rd = 1'b1;
    req_valid = 2'b01; req_cmd[31:0] = 32'h0000_4100; req_data[31:0] = 32'h0000_00AB;
    step();
    chk("wr_ready", 32'(req_ready), 32'h1);
    chk("wr_start_early", 32'(start), 32'h0);
    req_valid = 2'b00; req_cmd = '0; req_data = '0;
    step();
    chk("wr_ready_pulse", 32'(req_ready), 32'h0);
    chk("wr_nostart", 32'(start), 32'h0);
    chk("wr_cmd_idle", vme_cmd_reg, 32'h00F8_0000);
    step();
    chk("wr_start", 32'(start), 32'h1);
    chk("wr_cmd", vme_cmd_reg, 32'h0000_4100);
    chk("wr_dat", vme_dat_reg_in, 32'h0000_00AB);
    step();
    chk("wr_start_drop", 32'(start), 32'h0);
    chk("wr_cmd_back", vme_cmd_reg, 32'h00F8_0000);
    chk("wr_dat_back", vme_dat_reg_in, 32'h0);
    step();
    chk("wr_no_rsp", 32'(rsp_valid), 32'h0);
    vme_dat_wr = 1'b1; vme_dat_reg_out = 32'h1234_5678;
    step();
    chk("wr_rspv", 32'(rsp_valid), 32'h1);
    chk("wr_rspid", 32'(rsp_id), 32'h0);
    chk("wr_rsprd", 32'(rsp_rd), 32'h0);
    chk("wr_rspdata", rsp_data, 32'h0);
    chk("wr_rspto", 32'(rsp_timeout), 32'h0);
    vme_dat_wr = 1'b0;
    step();
    chk("wr_rsp_pulse", 32'(rsp_valid), 32'h0);

    // read from requester 1 (pointer now 1), strobe in the start cycle
    req_valid = 2'b10; req_cmd[63:32] = 32'h0200_3000; req_data[63:32] = 32'h1111_2222;
    step();
    chk("rd_ready", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    step(); step();
    chk("rd_start", 32'(start), 32'h1);
    chk("rd_cmd", vme_cmd_reg, 32'h0200_3000);
    chk("rd_dat", vme_dat_reg_in, 32'h1111_2222);
    vme_dat_wr = 1'b1; vme_dat_reg_out = 32'hDEAD_BEEF;
    step();
    chk("rd_rspv", 32'(rsp_valid), 32'h1);
    chk("rd_rspid", 32'(rsp_id), 32'h1);
    chk("rd_rsprd", 32'(rsp_rd), 32'h1);
    chk("rd_rspdata", rsp_data, 32'hDEAD_BEEF);
    vme_dat_wr = 1'b0;
    step();

    // contention: both valid, strobe held high (ignored outside WAIT), 5-cycle turnaround
    req_cmd = {32'h0000_4200, 32'h0000_4100};
    req_valid = 2'b11; vme_dat_wr = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_ready = (k % 5 == 1) ? (((k / 5) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("cont_ready_%0d", k), 32'(req_ready), 32'(exp_ready));
      chk($sformatf("cont_start_%0d", k), 32'(start), (k % 5 == 3) ? 32'h1 : 32'h0);
      chk($sformatf("cont_rspv_%0d", k), 32'(rsp_valid), (k % 5 == 4) ? 32'h1 : 32'h0);
      chk($sformatf("cont_rspid_%0d", k), 32'(rsp_id),
          (k % 5 == 4) ? 32'((k / 5) % 2) : 32'h0);
    end
    req_valid = 2'b00; vme_dat_wr = 1'b0;

    // timeout: read from requester 0 never completes
    req_valid = 2'b01; req_cmd[31:0] = 32'h0200_0010; vme_dat_reg_out = 32'hDEAD_BEEF;
    step();
    chk("to_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    step(); step();
    chk("to_start", 32'(start), 32'h1);
    early = 0;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (rsp_valid !== 1'b0) early++;
    end
    chk("to_early", 32'(early), 32'h0);
    step();
    chk("to_rspv", 32'(rsp_valid), 32'h1);
    chk("to_rspto", 32'(rsp_timeout), 32'h1);
    chk("to_rspdata", rsp_data, 32'h0);
    chk("to_rspid", 32'(rsp_id), 32'h0);

    // next grant after timeout, with decoder stalled for 10 cycles
    req_valid = 2'b01; req_cmd[31:0] = 32'h0000_5500; req_data[31:0] = 32'h0000_0077;
    vme_cmd_rd = 1'b0;
    step();
    chk("to_idle_ready", 32'(req_ready), 32'h0);
    chk("to_rsp_pulse", 32'(rsp_valid), 32'h0);
    step();
    chk("stall_ready", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (start !== 1'b0 || vme_cmd_reg !== 32'h00F8_0000) stall_bad++;
    end
    chk("stall_hold", 32'(stall_bad), 32'h0);
    vme_cmd_rd = 1'b1;
    step();
    chk("stall_go", 32'(start), 32'h0);
    step();
    chk("stall_start", 32'(start), 32'h1);
    chk("stall_cmd", vme_cmd_reg, 32'h0000_5500);
    chk("stall_dat", vme_dat_reg_in, 32'h0000_0077);

    // reset during WAIT: outputs drop at once, no response, pointer back to 0
    rst = 1'b1;
    #1;
    chk("rstw_start", 32'(start), 32'h0);
    chk("rstw_cmd", vme_cmd_reg, 32'h00F8_0000);
    chk("rstw_dat", vme_dat_reg_in, 32'h0);
    vme_dat_wr = 1'b1;
    step(); step();
    chk("rstw_rspv", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    step();
    vme_dat_wr = 1'b0;
    chk("rstw_ignored_wr", 32'(rsp_valid), 32'h0);
    req_valid = 2'b11;
    step();
    chk("rstw_ptr", 32'(req_ready), 32'h1);
    req_valid = 2'b00;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vme_cmd_arbiter.md
# vme_cmd_arbiter

Synthesizable scheduler that shares the single ODMB VME command path (start / vme_cmd_reg / vme_dat_reg_in → vme_dat_reg_out) between several on-board requesters. Examples are a self-test sequencer and a slow-control poller. It grants one requester at a time in round-robin order and issues that requester's command into the VME command decoder when the decoder signals it can accept one. It then waits for the decoder's data-write strobe and returns the read-back word, or a timeout, to the granted requester.

## Interface
Parameters:
- NREQ, 2, number of requesters (1..8)
- TIMEOUT, 1023, cycles to wait for vme_dat_wr after start before aborting (≥2)
- IDLE_CMD, 32'h00F8_0000, value driven on vme_cmd_reg when no command is issued
- RD_BIT, 25, bit of the command word that flags a read command

Ports:
- clk  in  1  system clock; only clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  requester i holds a pending command
- req_cmd  in  32*NREQ  command word of requester i, slice [32i+31:32i]
- req_data  in  32*NREQ  write-data word of requester i
- req_ready  out  NREQ  one-cycle pulse: command of requester i accepted
- vme_cmd_rd  in  1  decoder ready to take a command
- vme_dat_wr  in  1  decoder strobe: command complete, vme_dat_reg_out valid
- vme_dat_reg_out  in  32  read-back word from decoder
- start  out  1  one-cycle command strobe to decoder
- vme_cmd_reg  out  32  command word to decoder
- vme_dat_reg_in  out  32  write-data word to decoder
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_id  out  3  index of the responding requester
- rsp_data  out  32  read word; 0 for writes or timeout
- rsp_rd  out  1  response belongs to a read command
- rsp_timeout  out  1  command aborted by timeout

## Operation
- Reset values: start=0, vme_cmd_reg=IDLE_CMD, vme_dat_reg_in=0, req_ready=0, rsp_*=0, rr pointer=0, state=IDLE, timeout counter=0.
- All outputs are registered.
- FSM states:
  - IDLE: if any req_valid, select the first valid index at or after the rr pointer (modulo NREQ). Pulse req_ready[winner], latch cmd/data/id, set rr pointer = winner+1 mod NREQ, then go to ISSUE.
  - ISSUE: hold outputs idle. On the first cycle vme_cmd_rd=1, next cycle drive start=1 with the latched cmd/data for exactly one cycle, clear the counter, then go to WAIT.
  - WAIT: outputs return to IDLE_CMD/0. Count cycles.
    - vme_dat_wr=1: capture vme_dat_reg_out if cmd[RD_BIT]=1, else capture 0, then go to RESP.
    - counter reaches TIMEOUT: set timeout flag, data 0, then go to RESP.
  - RESP: pulse rsp_valid one cycle with id/data/rd/timeout, then go to IDLE.
- At most one command is outstanding. A requester must hold req_valid and its words stable until req_ready.
- vme_dat_wr outside WAIT is ignored. vme_cmd_rd outside ISSUE is ignored.
- A requester dropping req_valid after grant does not cancel its command.

## Timing
- Grant: req_ready pulses in the cycle after req_valid is sampled in IDLE.
- Issue: start rises 1 cycle after vme_cmd_rd is sampled high in ISSUE. If vme_cmd_rd is already high, start follows req_ready by 2 cycles.
- Response: rsp_valid rises 1 cycle after vme_dat_wr is sampled in WAIT. If vme_dat_wr arrives in the same cycle the counter hits TIMEOUT, vme_dat_wr wins and there is no timeout.
- Timeout: rsp_valid rises TIMEOUT+2 cycles after start.
- Back-to-back: the next grant is possible in the cycle after rsp_valid. Minimum turnaround is 5 cycles per command with immediate handshakes.
- The counter is ceil(log2(TIMEOUT+1)) bits and saturates, with no wrap.
- rst mid-command: immediate return to reset values. No response is produced for the aborted command and the decoder sees start drop.

## Structure
- Shared package odmb_vme_pkg:
  - IDLE_CMD default
  - RD_BIT position
  - state encoding (IDLE, ISSUE, WAIT, RESP)
  - response record fields
- Sub-module rr_arbiter: combinational round-robin priority select (valid vector + pointer → one-hot grant + index). Reusable for other shared ODMB resources.

## Test plan
- Single write: req_valid[0], cmd=32'h0000_4100, data=32'h0000_00AB, vme_cmd_rd high → start for 1 cycle with those words; vme_dat_wr 3 cycles later → rsp_valid, rsp_id=0, rsp_rd=0, rsp_data=0, rsp_timeout=0.
- Read: cmd=32'h0200_3000 (bit25), decoder returns 32'hDEAD_BEEF → rsp_rd=1, rsp_data=32'hDEADBEEF.
- Contention: both requesters valid continuously → grants alternate 0,1,0,1; each req_ready pulse is exactly 1 cycle.
- Timeout: vme_dat_wr never asserted, TIMEOUT=16 → rsp_valid 18 cycles after start, rsp_timeout=1, rsp_data=0; next grant proceeds.
- Ready stall: vme_cmd_rd low for 10 cycles after grant → start stays 0 and vme_cmd_reg=32'h00F80000 until 1 cycle after vme_cmd_rd rises.
- Reset in WAIT: assert rst → outputs at reset values within the same cycle, no rsp_valid; after release the rr pointer is 0.
